// File: rtl/coin_pkg.sv
// Shared types and constants for the coin collision and scoring stage.
package coin_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } cc_state_t;

    localparam int         COIN_W   = 16;
    localparam int         COIN_H   = 28;
    localparam logic [3:0] BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd_score_counter.sv
// Saturating multi-digit packed-BCD counter; holds at all nines.
module bcd_score_counter
    import coin_pkg::*;
#(
    parameter int SCORE_DIGITS = 3
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      inc,
    output logic [4*SCORE_DIGITS-1:0] score_bcd
);

    logic [4*SCORE_DIGITS-1:0] score_q, score_d;
    logic                      carry;
    logic                      saturated;

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        score_d   = score_q;
        carry     = inc;
        saturated = 1'b1;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (score_q[4*i +: 4] != BCD_NINE) saturated = 1'b0;
        end
        if (!saturated) begin
            for (int i = 0; i < SCORE_DIGITS; i++) begin
                if (carry) begin
                    if (score_q[4*i +: 4] == BCD_NINE) begin
                        score_d[4*i +: 4] = 4'd0;
                    end else begin
                        score_d[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments only.
    always_ff @(posedge Clk) begin
        if (Reset) score_q <= '0;
        else       score_q <= score_d;
    end

    assign score_bcd = score_q;

endmodule

// File: rtl/coin_collect.sv
// Per-frame player/coin collision scan with BCD scoring and a "+1" popup timer.
module coin_collect
    import coin_pkg::*;
#(
    parameter int NUM_COINS    = 4,
    parameter int PLAYER_W     = 16,
    parameter int PLAYER_H     = 28,
    parameter int SCORE_DIGITS = 3,
    parameter int POPUP_FRAMES = 16
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      frame_clk,
    input  logic                      level_restart,
    input  logic [9:0]                player_x,
    input  logic [9:0]                player_y,
    input  logic [NUM_COINS*10-1:0]   coin_x_flat,
    input  logic [NUM_COINS*10-1:0]   coin_y_flat,
    output logic [NUM_COINS-1:0]      coin_alive,
    output logic [4*SCORE_DIGITS-1:0] score_bcd,
    output logic                      collect_pulse,
    output logic                      popup_active,
    output logic [9:0]                popup_x,
    output logic [9:0]                popup_y
);

    localparam int               IDX_W    = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;
    localparam int               CNT_W    = $clog2(POPUP_FRAMES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COINS - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(POPUP_FRAMES);

    logic                 fc_d_q, fc_rise_q;
    cc_state_t            state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_COINS-1:0] alive_q, alive_d;
    logic                 pulse_q, pulse_d;
    logic                 popup_active_q, popup_active_d;
    logic [9:0]           popup_x_q, popup_x_d;
    logic [9:0]           popup_y_q, popup_y_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [9:0]  cx, cy;
    logic [10:0] px_e, py_e, cx_e, cy_e;
    logic        hit;

    // One extra bit on every operand keeps the edge sums from wrapping near 1023.
    always_comb begin
        cx   = coin_x_flat[int'(idx_q)*10 +: 10];
        cy   = coin_y_flat[int'(idx_q)*10 +: 10];
        px_e = {1'b0, player_x};
        py_e = {1'b0, player_y};
        cx_e = {1'b0, cx};
        cy_e = {1'b0, cy};
        hit  = (state_q == SCAN) && alive_q[idx_q]
            && (px_e < cx_e + 11'(COIN_W)) && (cx_e < px_e + 11'(PLAYER_W))
            && (py_e < cy_e + 11'(COIN_H)) && (cy_e < py_e + 11'(PLAYER_H));
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        alive_d        = alive_q;
        pulse_d        = 1'b0;
        popup_active_d = popup_active_q;
        popup_x_d      = popup_x_q;
        popup_y_d      = popup_y_q;
        cnt_d          = cnt_q;

        case (state_q)
            IDLE: if (fc_rise_q) begin
                state_d = SCAN;
                idx_d   = '0;
            end
            SCAN: if (idx_q == LAST_IDX) state_d = IDLE;
                  else                   idx_d   = idx_q + 1'b1;
            default: state_d = IDLE;
        endcase

        if (fc_rise_q && popup_active_q) begin
            cnt_d = cnt_q - 1'b1;
            if (popup_y_q != 10'd0) popup_y_d = popup_y_q - 10'd1;
            if (cnt_q == CNT_W'(1)) popup_active_d = 1'b0;
        end

        // A hit reloads the popup even if it is ticking this same cycle.
        if (hit) begin
            alive_d[idx_q] = 1'b0;
            pulse_d        = 1'b1;
            popup_x_d      = cx;
            popup_y_d      = cy;
            cnt_d          = CNT_LOAD;
            popup_active_d = 1'b1;
        end

        if (level_restart) begin
            state_d        = IDLE;
            idx_d          = '0;
            alive_d        = '1;
            pulse_d        = 1'b0;
            popup_active_d = 1'b0;
            cnt_d          = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_d_q         <= 1'b0;
            fc_rise_q      <= 1'b0;
            state_q        <= IDLE;
            idx_q          <= '0;
            alive_q        <= '1;
            pulse_q        <= 1'b0;
            popup_active_q <= 1'b0;
            popup_x_q      <= '0;
            popup_y_q      <= '0;
            cnt_q          <= '0;
        end else begin
            fc_d_q         <= frame_clk;
            fc_rise_q      <= frame_clk & ~fc_d_q;
            state_q        <= state_d;
            idx_q          <= idx_d;
            alive_q        <= alive_d;
            pulse_q        <= pulse_d;
            popup_active_q <= popup_active_d;
            popup_x_q      <= popup_x_d;
            popup_y_q      <= popup_y_d;
            cnt_q          <= cnt_d;
        end
    end

    bcd_score_counter #(
        .SCORE_DIGITS (SCORE_DIGITS)
    ) u_score (
        .Clk       (Clk),
        .Reset     (Reset),
        .inc       (hit && !level_restart),
        .score_bcd (score_bcd)
    );

    assign coin_alive    = alive_q;
    assign collect_pulse = pulse_q;
    assign popup_active  = popup_active_q;
    assign popup_x       = popup_x_q;
    assign popup_y       = popup_y_q;

endmodule

// File: tb/tb_coin_collect.sv
// Randomised and directed bench for coin_collect against a frame-level scoring model.
module tb_coin_collect;

    localparam int NC = 4;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          frame_clk = 1'b0;
    logic          level_restart = 1'b0;
    logic [9:0]    player_x = '0;
    logic [9:0]    player_y = '0;
    logic [NC*10-1:0] coin_x_flat = '0;
    logic [NC*10-1:0] coin_y_flat = '0;
    logic [NC-1:0] coin_alive;
    logic [11:0]   score_bcd;
    logic          collect_pulse;
    logic          popup_active;
    logic [9:0]    popup_x;
    logic [9:0]    popup_y;

    coin_collect dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .level_restart (level_restart),
        .player_x      (player_x),
        .player_y      (player_y),
        .coin_x_flat   (coin_x_flat),
        .coin_y_flat   (coin_y_flat),
        .coin_alive    (coin_alive),
        .score_bcd     (score_bcd),
        .collect_pulse (collect_pulse),
        .popup_active  (popup_active),
        .popup_x       (popup_x),
        .popup_y       (popup_y)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Scene and reference model state.
    int pxv, pyv;
    int cxv[NC];
    int cyv[NC];
    bit m_alive[NC];
    int m_score;
    bit m_act;
    int m_cnt;
    int m_px, m_py;

    function automatic logic [11:0] to_bcd(input int s);
        return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic bit overlaps(input int px, input int py, input int cx, input int cy);
        return (px < cx + 16) && (cx < px + 16) && (py < cy + 28) && (cy < py + 28);
    endfunction

    function automatic logic [NC-1:0] alive_vec();
        logic [NC-1:0] v;
        for (int i = 0; i < NC; i++) v[i] = m_alive[i];
        return v;
    endfunction

    task automatic apply_scene();
        player_x = 10'(pxv);
        player_y = 10'(pyv);
        for (int i = 0; i < NC; i++) begin
            coin_x_flat[10*i +: 10] = 10'(cxv[i]);
            coin_y_flat[10*i +: 10] = 10'(cyv[i]);
        end
    endtask

    // One frame edge; the model advances cycle by cycle from the frame rules and
    // every cycle's outputs are compared. restart_at > 2 raises level_restart mid-scan.
    task automatic run_frame(input int restart_at, output int npulse);
        bit aborted = 0;
        bit exp_pulse;
        npulse = 0;
        apply_scene();
        @(negedge Clk);
        frame_clk = 1'b1;
        for (int c = 1; c <= NC + 4; c++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (c == 2) frame_clk = 1'b0;
            exp_pulse = 0;
            if (restart_at != 0 && c == restart_at + 1) begin
                level_restart = 1'b0;
                aborted = 1;
                for (int i = 0; i < NC; i++) m_alive[i] = 1;
                m_act = 0;
                m_cnt = 0;
            end else begin
                if (c == 2 && m_act) begin
                    m_cnt--;
                    if (m_py > 0) m_py--;
                    if (m_cnt == 0) m_act = 0;
                end
                if (!aborted && c >= 3 && c - 3 < NC) begin
                    int k = c - 3;
                    if (m_alive[k] && overlaps(pxv, pyv, cxv[k], cyv[k])) begin
                        m_alive[k] = 0;
                        if (m_score < 999) m_score++;
                        m_px = cxv[k];
                        m_py = cyv[k];
                        m_cnt = 16;
                        m_act = 1;
                        exp_pulse = 1;
                    end
                end
            end
            if (collect_pulse) npulse++;
            n_checks += 6;
            if (coin_alive !== alive_vec()) begin
                n_errors++;
                $display("FAIL coin_alive cyc=%0d got %b exp %b", c, coin_alive, alive_vec());
            end
            if (score_bcd !== to_bcd(m_score)) begin
                n_errors++;
                $display("FAIL score cyc=%0d got %h exp %h", c, score_bcd, to_bcd(m_score));
            end
            if (collect_pulse !== exp_pulse) begin
                n_errors++;
                $display("FAIL collect_pulse cyc=%0d got %b exp %b", c, collect_pulse, exp_pulse);
            end
            if (popup_active !== m_act) begin
                n_errors++;
                $display("FAIL popup_active cyc=%0d got %b exp %b", c, popup_active, m_act);
            end
            if (popup_x !== 10'(m_px)) begin
                n_errors++;
                $display("FAIL popup_x cyc=%0d got %0d exp %0d", c, popup_x, m_px);
            end
            if (popup_y !== 10'(m_py)) begin
                n_errors++;
                $display("FAIL popup_y cyc=%0d got %0d exp %0d", c, popup_y, m_py);
            end
            if (restart_at != 0 && c == restart_at) level_restart = 1'b1;
        end
    endtask

    task automatic do_restart();
        @(negedge Clk);
        level_restart = 1'b1;
        @(negedge Clk);
        level_restart = 1'b0;
        for (int i = 0; i < NC; i++) m_alive[i] = 1;
        m_act = 0;
        m_cnt = 0;
        n_checks += 3;
        if (coin_alive !== alive_vec()) begin
            n_errors++;
            $display("FAIL restart_alive got %b exp %b", coin_alive, alive_vec());
        end
        if (popup_active !== 1'b0) begin
            n_errors++;
            $display("FAIL restart_popup got %b exp 0", popup_active);
        end
        if (score_bcd !== to_bcd(m_score)) begin
            n_errors++;
            $display("FAIL restart_score got %h exp %h", score_bcd, to_bcd(m_score));
        end
    endtask

    task automatic scene_far();
        pxv = 700; pyv = 700;
        for (int i = 0; i < NC; i++) begin
            cxv[i] = 600; cyv[i] = 0;
        end
    endtask

    task automatic test_reset();
        scene_far();
        apply_scene();
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < NC; i++) m_alive[i] = 1;
        m_score = 0; m_act = 0; m_cnt = 0; m_px = 0; m_py = 0;
        @(negedge Clk);
        n_checks += 6;
        if (coin_alive !== 4'b1111) begin n_errors++; $display("FAIL reset_alive got %b exp 1111", coin_alive); end
        if (score_bcd !== 12'h000) begin n_errors++; $display("FAIL reset_score got %h exp 000", score_bcd); end
        if (popup_active !== 1'b0) begin n_errors++; $display("FAIL reset_popup got %b exp 0", popup_active); end
        if (collect_pulse !== 1'b0) begin n_errors++; $display("FAIL reset_pulse got %b exp 0", collect_pulse); end
        if (popup_x !== 10'd0) begin n_errors++; $display("FAIL reset_popup_x got %0d exp 0", popup_x); end
        if (popup_y !== 10'd0) begin n_errors++; $display("FAIL reset_popup_y got %0d exp 0", popup_y); end
    endtask

    task automatic test_touching_edge();
        int np;
        scene_far();
        pxv = 84; pyv = 300;
        cxv[0] = 100; cyv[0] = 300;
        run_frame(0, np);
        n_checks += 3;
        if (coin_alive !== 4'b1111) begin n_errors++; $display("FAIL touch_alive got %b exp 1111", coin_alive); end
        if (score_bcd !== 12'h000) begin n_errors++; $display("FAIL touch_score got %h exp 000", score_bcd); end
        if (np !== 0) begin n_errors++; $display("FAIL touch_pulses got %0d exp 0", np); end
    endtask

    task automatic test_single_hit();
        int np;
        scene_far();
        pxv = 100; pyv = 300;
        cxv[1] = 108; cyv[1] = 300;
        run_frame(0, np);
        n_checks += 5;
        if (coin_alive !== 4'b1101) begin n_errors++; $display("FAIL single_alive got %b exp 1101", coin_alive); end
        if (score_bcd !== 12'h001) begin n_errors++; $display("FAIL single_score got %h exp 001", score_bcd); end
        if (np !== 1) begin n_errors++; $display("FAIL single_pulses got %0d exp 1", np); end
        if (popup_x !== 10'd108) begin n_errors++; $display("FAIL single_popup_x got %0d exp 108", popup_x); end
        if (popup_y !== 10'd300) begin n_errors++; $display("FAIL single_popup_y got %0d exp 300", popup_y); end
    endtask

    task automatic test_two_hits();
        int np;
        do_restart();
        scene_far();
        pxv = 100; pyv = 300;
        cxv[0] = 100; cyv[0] = 300;
        cxv[2] = 110; cyv[2] = 310;
        run_frame(0, np);
        n_checks += 4;
        if (score_bcd !== 12'h003) begin n_errors++; $display("FAIL two_score got %h exp 003", score_bcd); end
        if (np !== 2) begin n_errors++; $display("FAIL two_pulses got %0d exp 2", np); end
        if (popup_x !== 10'd110) begin n_errors++; $display("FAIL two_popup_x got %0d exp 110", popup_x); end
        if (coin_alive !== 4'b1010) begin n_errors++; $display("FAIL two_alive got %b exp 1010", coin_alive); end
        run_frame(0, np);
        n_checks += 2;
        if (score_bcd !== 12'h003) begin n_errors++; $display("FAIL two_again_score got %h exp 003", score_bcd); end
        if (np !== 0) begin n_errors++; $display("FAIL two_again_pulses got %0d exp 0", np); end
    endtask

    // The second frame of the two-hit scene was the first tick; 15 more expire the popup.
    task automatic test_popup_expiry();
        int np;
        for (int f = 0; f < 15; f++) begin
            run_frame(0, np);
            if (f == 13) begin
                n_checks++;
                if (popup_active !== 1'b1) begin n_errors++; $display("FAIL expiry_early got %b exp 1", popup_active); end
            end
        end
        n_checks += 2;
        if (popup_active !== 1'b0) begin n_errors++; $display("FAIL expiry_active got %b exp 0", popup_active); end
        if (popup_y !== 10'd294) begin n_errors++; $display("FAIL expiry_y got %0d exp 294", popup_y); end
    endtask

    task automatic test_restart_mid_scan();
        int np;
        do_restart();
        pxv = 100; pyv = 300;
        for (int i = 0; i < NC; i++) begin cxv[i] = 100; cyv[i] = 300; end
        run_frame(4, np);
        n_checks += 4;
        if (coin_alive !== 4'b1111) begin n_errors++; $display("FAIL midscan_alive got %b exp 1111", coin_alive); end
        if (popup_active !== 1'b0) begin n_errors++; $display("FAIL midscan_popup got %b exp 0", popup_active); end
        if (score_bcd !== 12'h005) begin n_errors++; $display("FAIL midscan_score got %h exp 005", score_bcd); end
        if (np !== 2) begin n_errors++; $display("FAIL midscan_pulses got %0d exp 2", np); end
    endtask

    task automatic test_random();
        int np;
        for (int f = 0; f < 20; f++) begin
            if (f % 5 == 4) do_restart();
            pxv = int'($urandom_range(700, 200));
            pyv = int'($urandom_range(600, 100));
            for (int i = 0; i < NC; i++) begin
                if ($urandom_range(1, 0) == 1) begin
                    cxv[i] = pxv + int'($urandom_range(40, 0)) - 20;
                    cyv[i] = pyv + int'($urandom_range(60, 0)) - 30;
                end else begin
                    cxv[i] = int'($urandom_range(1023, 0));
                    cyv[i] = int'($urandom_range(1023, 0));
                end
            end
            run_frame(0, np);
        end
    endtask

    task automatic test_saturation();
        int np;
        scene_far();
        pxv = 300; pyv = 300;
        cxv[0] = 300; cyv[0] = 300;
        while (m_score < 100) begin
            do_restart();
            run_frame(0, np);
        end
        if (m_score == 100) begin
            n_checks++;
            if (score_bcd !== 12'h100) begin n_errors++; $display("FAIL carry_099 got %h exp 100", score_bcd); end
        end
        for (int i = 0; i < NC; i++) begin cxv[i] = 300; cyv[i] = 300; end
        while (m_score < 999) begin
            do_restart();
            run_frame(0, np);
        end
        do_restart();
        run_frame(0, np);
        n_checks += 2;
        if (score_bcd !== 12'h999) begin n_errors++; $display("FAIL sat_score got %h exp 999", score_bcd); end
        if (np !== NC) begin n_errors++; $display("FAIL sat_pulses got %0d exp %0d", np, NC); end
    endtask

    initial begin
        test_reset();
        test_touching_edge();
        test_single_hit();
        test_two_hits();
        test_popup_expiry();
        test_restart_mid_scan();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/coin_collect.md
# coin_collect

Upstream collision and scoring stage for the coin sprites. Once per frame it checks the player's world-space bounding box against every live coin. On a hit it clears that coin's `coin_alive` bit, adds one to a saturating BCD score, and starts a short "+1" popup timer. Its `coin_alive` outputs drive the `coin_alive` inputs of the per-coin sprite instances, and its score drives the HUD digit renderer.

## Interface
Parameters:
- `NUM_COINS`, default 4: number of coins tracked (1–16).
- `PLAYER_W`, default 16: player box width in pixels.
- `PLAYER_H`, default 28: player box height in pixels.
- `SCORE_DIGITS`, default 3: number of BCD score digits.
- `POPUP_FRAMES`, default 16: popup lifetime in frames.

Ports:
- `Clk`  in  1: system clock.
- `Reset`  in  1: reset, synchronous, active-high; clock `Clk`.
- `frame_clk`  in  1: vertical-sync-rate strobe, asynchronous to the logic; the block edge-detects it on `Clk`.
- `level_restart`  in  1: one-`Clk` pulse that revives all coins.
- `player_x`, `player_y`  in  10: player top-left corner, world coordinates (screen X plus scroll).
- `coin_x_flat`, `coin_y_flat`  in  `NUM_COINS*10`: coin top-left corners; coin i occupies bits [10i+9:10i].
- `coin_alive`  out  `NUM_COINS`: 1 means the coin is still collectable.
- `score_bcd`  out  `4*SCORE_DIGITS`: score as packed BCD, least significant digit in bits [3:0].
- `collect_pulse`  out  1: one-`Clk` strobe for each coin collected.
- `popup_active`  out  1: popup is visible.
- `popup_x`, `popup_y`  out  10: popup position, world coordinates.

## Operation
- **Reset values:** `coin_alive` = all ones; `score_bcd` = 0; `collect_pulse` = 0; `popup_active` = 0; `popup_x` = 0; `popup_y` = 0; state = IDLE; scan index = 0; popup counter = 0.
- **Frame edge detection:** `fc_d <= frame_clk`; `fc_rise <= frame_clk & ~fc_d`. Both are registers.
- **FSM states:** IDLE, SCAN.
  - IDLE → SCAN when `fc_rise` is high; the scan index is loaded with 0.
  - In SCAN, one coin is evaluated per `Clk`, at index `idx`.
  - After evaluating `idx == NUM_COINS-1`, return to IDLE.
  - A `fc_rise` that arrives while in SCAN is ignored.
- **Hit test.** All comparisons use 11-bit unsigned arithmetic, so no sum wraps. A hit requires `coin_alive[idx]` and all of:
  - `px < cx+16`
  - `cx < px+PLAYER_W`
  - `py < cy+28`
  - `cy < py+PLAYER_H`
  - Box edges are exclusive: boxes that only touch do not hit.
- **On a hit:**
  - Clear `coin_alive[idx]`.
  - Increment the BCD score.
  - Raise `collect_pulse` for one cycle.
  - Load the popup: `popup_x = cx`, `popup_y = cy`, counter = `POPUP_FRAMES`, `popup_active` = 1.
  - If several coins hit in the same frame, each one scores and pulses separately; the popup reloads each time, so the last hit wins.
- **BCD increment:** per-digit carry (9 → 0, carry into the next digit). The score saturates at all nines: the next hit leaves it unchanged, but `collect_pulse` and the popup still fire.
- **Popup timer:** on each `fc_rise` while `popup_active` is set, the counter decrements and `popup_y` decrements by 1 (floors at 0). When the counter reaches 0, `popup_active` clears. A hit in the same cycle as a popup tick takes priority.
- **`level_restart`:**
  - Sets `coin_alive` to all ones, forces IDLE, and clears `popup_active` and the counter.
  - Does not change the score.
  - Beats a simultaneous `fc_rise` (no scan starts) and aborts any scan in progress.
- **`Reset`** overrides everything, including during a scan.

## Timing
- `frame_clk` first sampled high in cycle T gives `fc_rise` = 1 in T+1.
- The FSM enters SCAN in T+2 with `idx = 0`.
- Coin k is evaluated in cycle T+2+k; its `coin_alive` bit and score update are visible in T+3+k, and `collect_pulse` is high during T+3+k.
- A scan takes `NUM_COINS` cycles, which is far shorter than a frame.
- Coin positions must be stable while a scan is in progress.

## Structure
- Package `coin_pkg`:
  - state enum `cc_state_t` {IDLE, SCAN};
  - constants `COIN_W = 16`, `COIN_H = 28`;
  - localparam `BCD_NINE`.
- Sub-module `bcd_score_counter`, inputs `Clk`, `Reset`, `inc`; output `score_bcd`. It holds the saturating multi-digit BCD counter, parameterised by `SCORE_DIGITS`.
- The top level holds edge detection, the FSM, the hit test, and the popup timer.

## Test plan
- **Reset defaults:** assert `Reset`, release → `coin_alive` = 4'b1111, `score_bcd` = 12'h000, `popup_active` = 0.
- **Single hit:** player (100,300), coin1 (108,300), others far away; one frame edge → `coin_alive` = 4'b1101 at T+4, one `collect_pulse`, score 12'h001, popup (108,300).
- **Touching edge:** player (84,300), coin0 (100,300) → no hit; `coin_alive` unchanged, score unchanged.
- **Two hits in one frame:** coins 0 and 2 overlap the player; one edge → score 12'h002, two pulses at T+3 and T+5, popup at coin2's position. A second frame with the same positions → no further change.
- **Saturation:** preload by hits to 12'h999 (or force), then one hit → score stays 12'h999, pulse still fires. Also check 12'h099 + 1 = 12'h100.
- **Restart mid-scan:** `level_restart` during SCAN → `coin_alive` = 4'b1111 next cycle, `popup_active` = 0, score retained; popup expiry after 16 frames checked separately, with `popup_y` decreased by 16.
